mips_multicycle_ctrl: RTL

//  Multi-cycle control FSM sequencing the MIPS datapath: fetch, decode via instruction_parser fields, execute, memory, writeback.

---
 rtl/mips_multicycle_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and handshakes with a variable-latency unified memory, halting on timeout.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       fault
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWr, StWbMem, StExecR,
    StWbR, StExecI, StWbI, StBranch, StJump, StHalt
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;
  logic             is_lw_q;
  logic             in_mem;
  logic             timeout;
  logic             legal;

  // funct goes to the ALU control directly; zero is gated in the datapath by pc_write_cond.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout = in_mem && !mem_ready && (cnt_q == CntLast);
  assign legal   = opcode inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      is_lw_q <= 1'b0;
    end else begin
      // Non-mem states hold the counter at zero, so every mem state is entered with it cleared.
      cnt_q <= '0;
      if (in_mem && !mem_ready && !timeout) cnt_q <= cnt_q + CNT_W'(1);
      if (timeout) begin
        state_q <= StHalt;
        fault_q <= 1'b1;
      end else begin
        case (state_q)
          StFetch:   if (mem_ready) state_q <= StDecode;
          StDecode: begin
            is_lw_q <= (opcode == 6'h23);
            case (opcode)
              6'h00:        state_q <= StExecR;
              6'h23, 6'h2B: state_q <= StMemAddr;
              6'h08:        state_q <= StExecI;
              6'h04:        state_q <= StBranch;
              6'h02:        state_q <= StJump;
              default:      state_q <= StFetch;
            endcase
          end
          StMemAddr: state_q <= is_lw_q ? StMemRd : StMemWr;
          StMemRd:   if (mem_ready) state_q <= StWbMem;
          StMemWr:   if (mem_ready) state_q <= StFetch;
          StExecR:   state_q <= StWbR;
          StExecI:   state_q <= StWbI;
          StHalt:    state_q <= StHalt;
          default:   state_q <= StFetch;
        endcase
      end
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    fault         = 1'b0;
    if (!reset) begin
      fault = fault_q;
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b = 2'b11;
          illegal   = !legal;
        end
        StMemAddr, StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        StWbR: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StWbI:   reg_write = 1'b1;
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
